// File: rtl/pcap_dma_packer.sv
// pcap_dma_packer
//   Downstream end of the position-capture stream. Words from pcap_core are
//   buffered in a show-ahead FIFO and handed to the DMA engine in fixed-length
//   bursts. When the acquisition finishes, the partial tail is flushed as a
//   shorter burst, and end_o then pulses once.
//
// Parameters
//   AW           FIFO address width, depth = 2**AW words
//   BURST_LEN    words per full burst (1 .. 2**AW)
//   FULL_MARGIN  dma_full_o asserts when free words <= FULL_MARGIN
//
// Ports
//   clk_i, reset_i            clock, synchronous active-high reset
//   pcap_actv_i               capture active; a rising edge starts an acquisition
//   pcap_dat_i/_valid_i       capture word and its write strobe (no back-pressure)
//   pcap_done_i               acquisition finished, flush the buffer
//   dma_full_o                registered flow control back to pcap_core
//   dma_req_o/dma_ack_i       burst request / grant handshake
//   dma_len_o                 burst length, stable from request to last word
//   dma_dat_o/_valid_o        burst data stream, dma_ready_i accepts a word
//   dma_last_o                final word of the burst
//   fill_level_o              FIFO occupancy
//   overflow_o                sticky: a word was dropped on a full FIFO
//   end_o                     one-cycle pulse: acquisition fully drained
module pcap_dma_packer #(
  parameter int AW          = 10,
  parameter int BURST_LEN   = 256,
  parameter int FULL_MARGIN = 8
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          pcap_actv_i,
  input  logic [31:0]   pcap_dat_i,
  input  logic          pcap_dat_valid_i,
  input  logic          pcap_done_i,
  output logic          dma_full_o,
  output logic          dma_req_o,
  input  logic          dma_ack_i,
  output logic [AW:0]   dma_len_o,
  output logic [31:0]   dma_dat_o,
  output logic          dma_valid_o,
  input  logic          dma_ready_i,
  output logic          dma_last_o,
  output logic [AW:0]   fill_level_o,
  output logic          overflow_o,
  output logic          end_o
);

  localparam int          DEPTH   = 1 << AW;
  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);
  localparam logic [AW:0] BL_L    = (AW+1)'(BURST_LEN);
  localparam logic [AW:0] ONE_L   = (AW+1)'(1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_XFER = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [31:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_level;
  logic [AW:0]   r_len;
  logic [AW:0]   r_cnt;
  logic [1:0]    r_state;
  logic          r_ovf;
  logic          r_full;
  logic          r_done_seen;
  logic          r_actv_d;

  logic          w_push;
  logic          w_drop;
  logic          w_pop;
  logic          w_valid;
  logic          w_last;
  logic          w_actv_rise;
  logic [31:0]   w_free;

  assign w_valid     = (r_state == S_XFER);
  assign w_pop       = w_valid & dma_ready_i;
  assign w_last      = w_valid & (r_cnt == (r_len - ONE_L));
  // The push decision looks at the current level only; a same-cycle pop
  // does not make room for a word arriving on a full FIFO.
  assign w_push      = pcap_dat_valid_i & (r_level != DEPTH_L);
  assign w_drop      = pcap_dat_valid_i & (r_level == DEPTH_L);
  assign w_actv_rise = pcap_actv_i & ~r_actv_d;
  assign w_free      = 32'(DEPTH) - 32'(r_level);

  // ---- write stage: FIFO storage (data path, not reset) ----
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= pcap_dat_i;
    end
  end

  // ---- control stage: pointers, level, flags, burst FSM ----
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_level     <= '0;
      r_len       <= '0;
      r_cnt       <= '0;
      r_state     <= S_IDLE;
      r_ovf       <= 1'b0;
      r_full      <= 1'b0;
      r_done_seen <= 1'b0;
      r_actv_d    <= 1'b0;
    end else begin
      r_actv_d <= pcap_actv_i;

      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + ONE_L;
        2'b01:   r_level <= r_level - ONE_L;
        default: r_level <= r_level;
      endcase

      // A drop in the same cycle as a new acquisition still marks overflow.
      if (w_actv_rise) begin
        r_ovf <= 1'b0;
      end
      if (w_drop) begin
        r_ovf <= 1'b1;
      end

      r_full <= (w_free <= 32'(FULL_MARGIN)) | r_ovf;

      // A done pulse arriving while DONE clears the flag takes precedence,
      // so a back-to-back acquisition is not lost.
      if (w_actv_rise || (r_state == S_DONE)) begin
        r_done_seen <= 1'b0;
      end
      if (pcap_done_i) begin
        r_done_seen <= 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          if (r_level >= BL_L) begin
            r_len   <= BL_L;
            r_state <= S_REQ;
          end else if (r_done_seen && (r_level != '0)) begin
            r_len   <= r_level;
            r_state <= S_REQ;
          end else if (r_done_seen) begin
            r_state <= S_DONE;
          end
        end
        S_REQ: begin
          if (dma_ack_i) begin
            r_cnt   <= '0;
            r_state <= S_XFER;
          end
        end
        S_XFER: begin
          // len never exceeds the level seen at request time, and only this
          // burst pops, so the FIFO cannot run dry mid-burst.
          if (w_pop) begin
            r_cnt <= r_cnt + ONE_L;
            if (w_last) begin
              r_state <= S_IDLE;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign dma_full_o   = r_full;
  assign dma_req_o    = (r_state == S_REQ);
  assign dma_len_o    = r_len;
  assign dma_valid_o  = w_valid;
  assign dma_dat_o    = w_valid ? r_mem[r_rd_ptr] : 32'd0;
  assign dma_last_o   = w_last;
  assign fill_level_o = r_level;
  assign overflow_o   = r_ovf;
  assign end_o        = (r_state == S_DONE);

endmodule

// File: tb/tb_pcap_dma_packer.sv
`timescale 1ns/1ps
module tb_pcap_dma_packer;
  localparam int AW    = 10;
  localparam int BL    = 256;
  localparam int FM    = 8;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- DUT A: default geometry ----------------
  logic          a_rst, a_actv, a_dv, a_done, a_ack, a_rdy;
  logic [31:0]   a_dat;
  logic          a_full, a_req, a_valid, a_last, a_ovf, a_end;
  logic [AW:0]   a_len, a_lvl;
  logic [31:0]   a_dout;

  pcap_dma_packer #(.AW(AW), .BURST_LEN(BL), .FULL_MARGIN(FM)) dut_a (
    .clk_i(clk), .reset_i(a_rst), .pcap_actv_i(a_actv), .pcap_dat_i(a_dat),
    .pcap_dat_valid_i(a_dv), .pcap_done_i(a_done), .dma_full_o(a_full),
    .dma_req_o(a_req), .dma_ack_i(a_ack), .dma_len_o(a_len), .dma_dat_o(a_dout),
    .dma_valid_o(a_valid), .dma_ready_i(a_rdy), .dma_last_o(a_last),
    .fill_level_o(a_lvl), .overflow_o(a_ovf), .end_o(a_end)
  );

  // ---------------- DUT B: small FIFO for overflow ----------------
  logic          b_rst, b_actv, b_dv, b_done, b_ack, b_rdy;
  logic [31:0]   b_dat;
  logic          b_full, b_req, b_valid, b_last, b_ovf, b_end;
  logic [4:0]    b_len, b_lvl;
  logic [31:0]   b_dout;

  pcap_dma_packer #(.AW(4), .BURST_LEN(8), .FULL_MARGIN(2)) dut_b (
    .clk_i(clk), .reset_i(b_rst), .pcap_actv_i(b_actv), .pcap_dat_i(b_dat),
    .pcap_dat_valid_i(b_dv), .pcap_done_i(b_done), .dma_full_o(b_full),
    .dma_req_o(b_req), .dma_ack_i(b_ack), .dma_len_o(b_len), .dma_dat_o(b_dout),
    .dma_valid_o(b_valid), .dma_ready_i(b_rdy), .dma_last_o(b_last),
    .fill_level_o(b_lvl), .overflow_o(b_ovf), .end_o(b_end)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- behavioural model of DUT A ----------------
  logic [31:0] q[$];
  logic [31:0] out_log[$];
  int          len_log[$];
  int          last_idx[$];
  int          end_cnt = 0;
  bit          m_live = 0;
  bit          m_ovf, m_done, m_actv_d, m_full, m_burst, m_pend, m_prev_done;
  int          m_len, m_cnt, m_prev_size;

  function automatic logic [31:0] out_at(input int i);
    return (i < out_log.size()) ? out_log[i] : 32'hDEAD_BEEF;
  endfunction
  function automatic int len_at(input int i);
    return (i < len_log.size()) ? len_log[i] : -1;
  endfunction
  function automatic int last_at(input int i);
    return (i < last_idx.size()) ? last_idx[i] : -1;
  endfunction

  always @(negedge clk) begin
    bit do_push;
    int exp_len;
    if (m_live) begin
      chk("fill_level", 64'(a_lvl), 64'(q.size()));
      chk("overflow", 64'(a_ovf), 64'(m_ovf));
      chk("dma_full", 64'(a_full), 64'(m_full));
      chk("valid_in_burst", 64'(a_valid), 64'(m_burst));
      if (m_pend) chk("req_held", 64'(a_req), 64'd1);
      if (a_req && !m_pend) begin
        // a new request covers a full burst, or the whole remainder on a flush
        exp_len = (m_prev_size >= BL) ? BL : m_prev_size;
        chk("req_len", 64'(a_len), 64'(exp_len));
        chk("req_nonzero", 64'(m_prev_size > 0), 64'd1);
        if (m_prev_size < BL) chk("flush_needs_done", 64'(m_prev_done), 64'd1);
        m_pend = 1;
        m_len  = exp_len;
      end
      if (a_req) chk("len_req", 64'(a_len), 64'(m_len));
      if (a_valid) begin
        chk("len_xfer", 64'(a_len), 64'(m_len));
        chk("dat", 64'(a_dout), 64'((q.size() > 0) ? q[0] : 32'hDEAD_BEEF));
        chk("last", 64'(a_last), 64'(m_cnt == m_len - 1));
      end else begin
        chk("last_idle", 64'(a_last), 64'd0);
      end
      if (a_end) begin
        chk("end_empty", 64'(q.size()), 64'd0);
        chk("end_done", 64'(m_done), 64'd1);
        chk("end_no_burst", 64'(m_burst | m_pend), 64'd0);
        end_cnt++;
      end
    end
    // advance the model to the state after the coming rising edge
    m_prev_size = q.size();
    m_prev_done = m_done;
    if (a_rst) begin
      q.delete();
      m_ovf = 0; m_done = 0; m_actv_d = 0; m_full = 0;
      m_burst = 0; m_pend = 0; m_cnt = 0; m_len = 0;
      m_prev_size = 0; m_prev_done = 0;
      m_live = 1;
    end else if (m_live) begin
      m_full  = ((DEPTH - q.size()) <= FM) || m_ovf;
      do_push = a_dv && (q.size() < DEPTH);
      if (a_valid && a_rdy) begin
        out_log.push_back(a_dout);
        if (a_last) begin
          last_idx.push_back(out_log.size() - 1);
          m_burst = 0;
        end
        m_cnt++;
        if (q.size() > 0) void'(q.pop_front());
      end
      if (a_req && a_ack) begin
        m_burst = 1; m_cnt = 0; m_pend = 0;
        len_log.push_back(m_len);
      end
      if (do_push) q.push_back(a_dat);
      if (a_actv && !m_actv_d) begin
        m_ovf = 0; m_done = 0;
      end
      if (a_dv && !do_push) m_ovf = 1;
      if (a_end) m_done = 0;
      if (a_done) m_done = 1;
      m_actv_d = a_actv;
    end
  end

  task automatic clear_logs();
    out_log.delete(); len_log.delete(); last_idx.delete(); end_cnt = 0;
  endtask

  task automatic new_acq();
    a_actv = 1'b0; tick(); a_actv = 1'b1; tick();
  endtask

  task automatic wait_words(input int n, input int budget);
    for (int k = 0; k < budget && out_log.size() < n; k++) tick();
  endtask

  task automatic wait_end(input int n, input int budget);
    for (int k = 0; k < budget && end_cnt < n; k++) begin
      a_rdy = (k % 2 == 0) ? a_rdy : 1'b1;
      tick();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int bad;
    bit seen_end, seen_req;
    logic fullh [20];
    a_rst = 1; a_actv = 0; a_dv = 0; a_done = 0; a_ack = 0; a_rdy = 0; a_dat = '0;
    b_rst = 1; b_actv = 0; b_dv = 0; b_done = 0; b_ack = 0; b_rdy = 0; b_dat = '0;
    repeat (3) tick();

    // reset state
    chk("rst_req", 64'(a_req), 64'd0);
    chk("rst_valid", 64'(a_valid), 64'd0);
    chk("rst_lvl", 64'(a_lvl), 64'd0);
    chk("rst_len", 64'(a_len), 64'd0);
    chk("rst_full", 64'(a_full), 64'd0);
    chk("rst_end", 64'(a_end), 64'd0);
    a_rst = 0; b_rst = 0;

    // 1: one full burst of 0..255
    a_ack = 1; a_rdy = 1;
    new_acq();
    clear_logs();
    for (int i = 0; i < 256; i++) begin
      a_dv = 1; a_dat = 32'(i); tick();
    end
    a_dv = 0;
    wait_words(256, 1000);
    chk("t1_words", 64'(out_log.size()), 64'd256);
    chk("t1_nbursts", 64'(len_log.size()), 64'd1);
    chk("t1_len", 64'(len_at(0)), 64'd256);
    chk("t1_first", 64'(out_at(0)), 64'd0);
    chk("t1_lastword", 64'(out_at(255)), 64'd255);
    chk("t1_lastidx", 64'(last_at(0)), 64'd255);
    tick();
    chk("t1_lvl", 64'(a_lvl), 64'd0);

    // 2: 300 words then done -> 256 + flush of 44, then end
    new_acq();
    clear_logs();
    for (int i = 0; i < 300; i++) begin
      a_dv = 1; a_dat = 32'(i); tick();
    end
    a_dv = 0; a_done = 1; tick(); a_done = 0;
    wait_end(1, 2000);
    chk("t2_end", 64'(end_cnt), 64'd1);
    chk("t2_lens0", 64'(len_at(0)), 64'd256);
    chk("t2_lens1", 64'(len_at(1)), 64'd44);
    chk("t2_w256", 64'(out_at(256)), 64'd256);
    chk("t2_w299", 64'(out_at(299)), 64'd299);
    chk("t2_last1", 64'(last_at(1)), 64'd299);
    repeat (5) tick();
    chk("t2_no_second_end", 64'(end_cnt), 64'd1);
    chk("t2_idle_req", 64'(a_req), 64'd0);

    // 4: ready toggling during XFER with concurrent pushes
    new_acq();
    clear_logs();
    for (int i = 0; i < 296; i++) begin
      a_dv = 1; a_dat = 32'(5000 + i);
      a_rdy = (i % 2 == 1);
      tick();
    end
    a_dv = 0; a_done = 1; tick(); a_done = 0;
    for (int k = 0; k < 3000 && end_cnt < 1; k++) begin
      a_rdy = ~a_rdy; tick();
    end
    a_rdy = 1;
    chk("t4_end", 64'(end_cnt), 64'd1);
    chk("t4_count", 64'(out_log.size()), 64'd296);
    chk("t4_lens0", 64'(len_at(0)), 64'd256);
    chk("t4_lens1", 64'(len_at(1)), 64'd40);
    bad = 0;
    for (int i = 0; i < 296; i++) if (out_at(i) != 32'(5000 + i)) bad++;
    chk("t4_order", 64'(bad), 64'd0);

    // 5: done with empty FIFO, then done coincident with a write
    clear_logs();
    a_done = 1; tick(); a_done = 0;
    seen_end = 0; seen_req = 0;
    for (int k = 0; k < 3; k++) begin
      if (a_end) seen_end = 1;
      if (a_req) seen_req = 1;
      tick();
    end
    chk("t5_end_fast", 64'(seen_end), 64'd1);
    chk("t5_no_req", 64'(seen_req), 64'd0);
    clear_logs();
    a_dv = 1; a_dat = 32'd77; a_done = 1; tick();
    a_dv = 0; a_done = 0;
    wait_end(1, 50);
    chk("t5_flush_len", 64'(len_at(0)), 64'd1);
    chk("t5_flush_word", 64'(out_at(0)), 64'd77);
    chk("t5_flush_end", 64'(end_cnt), 64'd1);

    // 6: reset in the middle of a burst
    new_acq();
    clear_logs();
    for (int i = 0; i < 256; i++) begin
      a_dv = 1; a_dat = 32'(9000 + i); tick();
    end
    a_dv = 0;
    wait_words(100, 500);
    a_rst = 1; tick(); a_rst = 0;
    chk("t6_req", 64'(a_req), 64'd0);
    chk("t6_valid", 64'(a_valid), 64'd0);
    chk("t6_last", 64'(a_last), 64'd0);
    chk("t6_dat", 64'(a_dout), 64'd0);
    chk("t6_len", 64'(a_len), 64'd0);
    chk("t6_lvl", 64'(a_lvl), 64'd0);
    chk("t6_end", 64'(a_end), 64'd0);
    repeat (10) tick();
    chk("t6_no_lastevt", 64'(last_idx.size()), 64'd0);
    chk("t6_no_endevt", 64'(end_cnt), 64'd0);
    new_acq();
    clear_logs();
    for (int i = 0; i < 256; i++) begin
      a_dv = 1; a_dat = 32'(i * 3); tick();
    end
    a_dv = 0;
    wait_words(256, 1000);
    chk("t6_again_len", 64'(len_at(0)), 64'd256);
    chk("t6_again_w255", 64'(out_at(255)), 64'd765);
    chk("t6_again_last", 64'(last_at(0)), 64'd255);

    // 3: small FIFO, no grant, overflow and flow control
    b_actv = 1; b_rdy = 1; b_ack = 0;
    tick();
    for (int i = 0; i < 20; i++) begin
      b_dv = 1; b_dat = 32'(i); tick();
      fullh[i] = b_full;
    end
    b_dv = 0;
    chk("t3_full_lvl13", 64'(fullh[13]), 64'd0);
    chk("t3_full_lvl14", 64'(fullh[14]), 64'd1);
    tick();
    chk("t3_lvl", 64'(b_lvl), 64'd16);
    chk("t3_ovf", 64'(b_ovf), 64'd1);
    chk("t3_full", 64'(b_full), 64'd1);
    chk("t3_req", 64'(b_req), 64'd1);
    chk("t3_len", 64'(b_len), 64'd8);
    b_actv = 0; tick(); b_actv = 1; tick();
    chk("t3_ovf_cleared", 64'(b_ovf), 64'd0);
    b_ack = 1;
    out_log.delete();
    for (int k = 0; k < 60; k++) begin
      if (b_valid && b_rdy) out_log.push_back(b_dout);
      tick();
    end
    chk("t3_drained", 64'(out_log.size()), 64'd16);
    bad = 0;
    for (int i = 0; i < 16; i++) if (out_at(i) != 32'(i)) bad++;
    chk("t3_order", 64'(bad), 64'd0);
    chk("t3_lvl_end", 64'(b_lvl), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
